// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer types and sizing.
// ROB_SIZE / ROB_IDX_W are also used by the register file (rob_ix) and the
// reservation stations, so the tag width stays consistent across the core.
package reorder_buffer_pkg;

  localparam int ROB_SIZE   = 8;
  localparam int ROB_IDX_W  = $clog2(ROB_SIZE);
  localparam int ROB_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [ROB_DATA_W-1:0] data;
    logic                  mispredict;
    logic [31:0]           target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer.
// Allocation side : alloc_valid_in/we/rd in, alloc_ready_out, alloc_idx_out (= tail).
// Result side     : cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in.
// Commit side     : commit_valid_out, we_out, wa_out, wd_out, wrob_ix_out (registered pulses).
// Flush side      : flush_out, flush_addrs_out, redirect_pc_out (registered pulses).
// Status          : count_out = occupied entries.
// clk_in, rst_in (synchronous, active-low).
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int SIZE   = ROB_SIZE,
  parameter int IDX_W  = $clog2(SIZE),
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              alloc_valid_in,
  input  logic              alloc_we_in,
  input  logic [4:0]        alloc_rd_in,
  output logic              alloc_ready_out,
  output logic [IDX_W-1:0]  alloc_idx_out,
  input  logic              cdb_valid_in,
  input  logic [IDX_W-1:0]  cdb_idx_in,
  input  logic [DATA_W-1:0] cdb_data_in,
  input  logic              cdb_mispredict_in,
  input  logic [31:0]       cdb_target_in,
  output logic              we_out,
  output logic [4:0]        wa_out,
  output logic [DATA_W-1:0] wd_out,
  output logic [IDX_W-1:0]  wrob_ix_out,
  output logic              commit_valid_out,
  output logic              flush_out,
  output logic [SIZE-1:0]   flush_addrs_out,
  output logic [31:0]       redirect_pc_out,
  output logic [IDX_W:0]    count_out
);

  localparam logic [IDX_W:0]  FULL_CNT = (IDX_W+1)'(SIZE);
  localparam logic [SIZE-1:0] ONE_HOT0 = {{(SIZE-1){1'b0}}, 1'b1};

  rob_entry_t       entry [SIZE];
  rob_entry_t       head_ent;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [SIZE-1:0]  busy_mask;
  logic             flush_pending;
  logic             commit_fire;
  logic             alloc_fire;

  assign head_ent      = entry[head];
  assign commit_fire   = head_ent.busy && head_ent.done;
  assign flush_pending = commit_fire && head_ent.mispredict;

  // Full blocks allocation even when the head retires this cycle.
  assign alloc_ready_out = (count != FULL_CNT) && !flush_pending;
  assign alloc_idx_out   = tail;
  assign alloc_fire      = alloc_valid_in && alloc_ready_out;
  assign count_out       = count;

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < SIZE; i++) busy_mask[i] = entry[i].busy;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < SIZE; i++) entry[i] <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      we_out           <= 1'b0;
      wa_out           <= '0;
      wd_out           <= '0;
      wrob_ix_out      <= '0;
      commit_valid_out <= 1'b0;
      flush_out        <= 1'b0;
      flush_addrs_out  <= '0;
      redirect_pc_out  <= '0;
    end else begin
      we_out           <= 1'b0;
      wa_out           <= '0;
      wd_out           <= '0;
      wrob_ix_out      <= '0;
      commit_valid_out <= 1'b0;
      flush_out        <= 1'b0;
      flush_addrs_out  <= '0;
      redirect_pc_out  <= '0;

      if (commit_fire) begin
        commit_valid_out <= 1'b1;
        we_out           <= head_ent.we;
        wa_out           <= head_ent.rd;
        wd_out           <= head_ent.data;
        wrob_ix_out      <= head;
      end

      if (flush_pending) begin
        // Head still writes back (link register); everything younger is dropped
        // and any CDB result landing this cycle is discarded with it.
        flush_out       <= 1'b1;
        flush_addrs_out <= busy_mask & ~(ONE_HOT0 << head);
        redirect_pc_out <= head_ent.target;
        for (int i = 0; i < SIZE; i++) entry[i] <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (cdb_valid_in && entry[cdb_idx_in].busy) begin
          entry[cdb_idx_in].done       <= 1'b1;
          entry[cdb_idx_in].data       <= cdb_data_in;
          entry[cdb_idx_in].mispredict <= cdb_mispredict_in;
          entry[cdb_idx_in].target     <= cdb_target_in;
        end
        if (alloc_fire) begin
          entry[tail].busy       <= 1'b1;
          entry[tail].done       <= 1'b0;
          entry[tail].we         <= alloc_we_in && (alloc_rd_in != 5'd0);
          entry[tail].rd         <= alloc_rd_in;
          entry[tail].mispredict <= 1'b0;
          tail                   <= tail + 1'b1;
        end
        // Placed last so it wins over a stray CDB write to the retiring tag.
        if (commit_fire) begin
          entry[head].busy <= 1'b0;
          entry[head].done <= 1'b0;
          head             <= head + 1'b1;
        end
        case ({alloc_fire, commit_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a program-order queue model runs
// alongside every cycle, plus a directed vector table and hand sequences.
module tb_reorder_buffer;

  localparam int SIZE = 8;

  logic        clk_in;
  logic        rst_in;
  logic        alloc_valid_in;
  logic        alloc_we_in;
  logic [4:0]  alloc_rd_in;
  logic        alloc_ready_out;
  logic [2:0]  alloc_idx_out;
  logic        cdb_valid_in;
  logic [2:0]  cdb_idx_in;
  logic [31:0] cdb_data_in;
  logic        cdb_mispredict_in;
  logic [31:0] cdb_target_in;
  logic        we_out;
  logic [4:0]  wa_out;
  logic [31:0] wd_out;
  logic [2:0]  wrob_ix_out;
  logic        commit_valid_out;
  logic        flush_out;
  logic [7:0]  flush_addrs_out;
  logic [31:0] redirect_pc_out;
  logic [3:0]  count_out;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .alloc_valid_in(alloc_valid_in), .alloc_we_in(alloc_we_in), .alloc_rd_in(alloc_rd_in),
    .alloc_ready_out(alloc_ready_out), .alloc_idx_out(alloc_idx_out),
    .cdb_valid_in(cdb_valid_in), .cdb_idx_in(cdb_idx_in), .cdb_data_in(cdb_data_in),
    .cdb_mispredict_in(cdb_mispredict_in), .cdb_target_in(cdb_target_in),
    .we_out(we_out), .wa_out(wa_out), .wd_out(wd_out), .wrob_ix_out(wrob_ix_out),
    .commit_valid_out(commit_valid_out), .flush_out(flush_out),
    .flush_addrs_out(flush_addrs_out), .redirect_pc_out(redirect_pc_out),
    .count_out(count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: entries kept in program order -------------
  typedef struct {
    int          tag;
    bit          we;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
    bit          mis;
    logic [31:0] target;
  } m_ent_t;

  m_ent_t      q[$];
  int          next_tag = 0;
  logic        m_cv, m_we, m_flush;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_pc;
  logic [2:0]  m_wix;
  logic [7:0]  m_mask;

  function automatic bit model_ready();
    if (q.size() >= SIZE) return 1'b0;
    if (q.size() > 0) begin
      if (q[0].done && q[0].mis) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit tag_done(input int t);
    foreach (q[i]) if (q[i].tag == t && q[i].done) return 1'b1;
    return 1'b0;
  endfunction

  // Evaluated with the inputs about to be sampled at the next edge.
  task automatic model_step();
    bit     ready, commit;
    m_ent_t e;
    m_cv = 0; m_we = 0; m_wa = '0; m_wd = '0; m_wix = '0;
    m_flush = 0; m_mask = '0; m_pc = '0;
    if (!rst_in) begin
      q.delete();
      next_tag = 0;
      return;
    end
    ready  = model_ready();
    commit = (q.size() > 0) && q[0].done;
    if (commit) begin
      m_cv  = 1;
      m_we  = q[0].we;
      m_wa  = q[0].rd;
      m_wd  = q[0].data;
      m_wix = 3'(q[0].tag);
      if (q[0].mis) begin
        m_flush = 1;
        m_pc    = q[0].target;
        for (int i = 1; i < q.size(); i++) m_mask[q[i].tag] = 1'b1;
        q.delete();
        next_tag = 0;
        return;
      end
    end
    if (cdb_valid_in) begin
      foreach (q[i]) begin
        if (q[i].tag == int'(cdb_idx_in)) begin
          e = q[i];
          e.done = 1; e.data = cdb_data_in; e.mis = cdb_mispredict_in; e.target = cdb_target_in;
          q[i] = e;
        end
      end
    end
    if (commit) void'(q.pop_front());
    if (alloc_valid_in && ready) begin
      e.tag = next_tag; e.we = alloc_we_in && (alloc_rd_in != 0); e.rd = alloc_rd_in;
      e.done = 0; e.data = '0; e.mis = 0; e.target = '0;
      q.push_back(e);
      next_tag = (next_tag + 1) % SIZE;
    end
  endtask

  task automatic check_model();
    chk("m.commit_valid", 32'(commit_valid_out), 32'(m_cv));
    chk("m.we",           32'(we_out),           32'(m_we));
    chk("m.wa",           32'(wa_out),           32'(m_wa));
    chk("m.wd",           wd_out,                m_wd);
    chk("m.wrob_ix",      32'(wrob_ix_out),      32'(m_wix));
    chk("m.flush",        32'(flush_out),        32'(m_flush));
    chk("m.flush_addrs",  32'(flush_addrs_out),  32'(m_mask));
    chk("m.redirect_pc",  redirect_pc_out,       m_pc);
    chk("m.count",        32'(count_out),        q.size());
    chk("m.ready",        32'(alloc_ready_out),  32'(model_ready()));
    chk("m.alloc_idx",    32'(alloc_idx_out),    next_tag);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    check_model();
  endtask

  task automatic idle();
    alloc_valid_in = 0; alloc_we_in = 0; alloc_rd_in = '0;
    cdb_valid_in = 0; cdb_idx_in = '0; cdb_data_in = '0;
    cdb_mispredict_in = 0; cdb_target_in = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 0;
    tick();
    rst_in = 1;
  endtask

  task automatic alloc(input logic [4:0] rd);
    idle();
    alloc_valid_in = 1; alloc_we_in = 1; alloc_rd_in = rd;
  endtask

  task automatic cdb(input logic [2:0] idx, input logic [31:0] d, input logic mis, input logic [31:0] tgt);
    cdb_valid_in = 1; cdb_idx_in = idx; cdb_data_in = d;
    cdb_mispredict_in = mis; cdb_target_in = tgt;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        av, aw;
    logic [4:0]  rd;
    logic        cv;
    logic [2:0]  ci;
    logic [31:0] cd;
    logic        e_cv, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_wix;
    logic [3:0]  e_cnt;
    logic        e_rdy;
    logic [2:0]  e_idx;
  } vec_t;

  vec_t vec [14];

  initial begin
    // av aw rd     cv ci    cd         | cv we wa     wd         wix   cnt    rdy idx
    vec[0]  = '{1'b1,1'b1,5'd5, 1'b0,3'd0,32'h0,  1'b0,1'b0,5'd0,32'h0,  3'd0,4'd1,1'b1,3'd1};
    vec[1]  = '{1'b1,1'b1,5'd6, 1'b0,3'd0,32'h0,  1'b0,1'b0,5'd0,32'h0,  3'd0,4'd2,1'b1,3'd2};
    vec[2]  = '{1'b1,1'b1,5'd7, 1'b0,3'd0,32'h0,  1'b0,1'b0,5'd0,32'h0,  3'd0,4'd3,1'b1,3'd3};
    vec[3]  = '{1'b0,1'b0,5'd0, 1'b1,3'd1,32'h22, 1'b0,1'b0,5'd0,32'h0,  3'd0,4'd3,1'b1,3'd3};
    vec[4]  = '{1'b0,1'b0,5'd0, 1'b1,3'd0,32'h11, 1'b0,1'b0,5'd0,32'h0,  3'd0,4'd3,1'b1,3'd3};
    vec[5]  = '{1'b0,1'b0,5'd0, 1'b0,3'd0,32'h0,  1'b1,1'b1,5'd5,32'h11, 3'd0,4'd2,1'b1,3'd3};
    vec[6]  = '{1'b0,1'b0,5'd0, 1'b0,3'd0,32'h0,  1'b1,1'b1,5'd6,32'h22, 3'd1,4'd1,1'b1,3'd3};
    vec[7]  = '{1'b0,1'b0,5'd0, 1'b1,3'd2,32'h33, 1'b0,1'b0,5'd0,32'h0,  3'd0,4'd1,1'b1,3'd3};
    vec[8]  = '{1'b0,1'b0,5'd0, 1'b0,3'd0,32'h0,  1'b1,1'b1,5'd7,32'h33, 3'd2,4'd0,1'b1,3'd3};
    vec[9]  = '{1'b1,1'b1,5'd0, 1'b0,3'd0,32'h0,  1'b0,1'b0,5'd0,32'h0,  3'd0,4'd1,1'b1,3'd4};
    vec[10] = '{1'b0,1'b0,5'd0, 1'b1,3'd3,32'h5,  1'b0,1'b0,5'd0,32'h0,  3'd0,4'd1,1'b1,3'd4};
    vec[11] = '{1'b0,1'b0,5'd0, 1'b0,3'd0,32'h0,  1'b1,1'b0,5'd0,32'h5,  3'd3,4'd0,1'b1,3'd4};
    vec[12] = '{1'b0,1'b0,5'd0, 1'b1,3'd3,32'h99, 1'b0,1'b0,5'd0,32'h0,  3'd0,4'd0,1'b1,3'd4};
    vec[13] = '{1'b0,1'b0,5'd0, 1'b0,3'd0,32'h0,  1'b0,1'b0,5'd0,32'h0,  3'd0,4'd0,1'b1,3'd4};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 0;
    idle();
    #1;
    tick();
    chk("reset.count", 32'(count_out), 32'd0);
    chk("reset.ready", 32'(alloc_ready_out), 32'd1);
    chk("reset.commit", 32'(commit_valid_out), 32'd0);
    rst_in = 1;

    // ---- in-order commit, rd=0 suppression, CDB to a free tag ----
    for (int i = 0; i < 14; i++) begin
      idle();
      alloc_valid_in = vec[i].av; alloc_we_in = vec[i].aw; alloc_rd_in = vec[i].rd;
      cdb_valid_in = vec[i].cv; cdb_idx_in = vec[i].ci; cdb_data_in = vec[i].cd;
      tick();
      chk($sformatf("row%0d.cv", i),    32'(commit_valid_out), 32'(vec[i].e_cv));
      chk($sformatf("row%0d.we", i),    32'(we_out),           32'(vec[i].e_we));
      chk($sformatf("row%0d.wa", i),    32'(wa_out),           32'(vec[i].e_wa));
      chk($sformatf("row%0d.wd", i),    wd_out,                vec[i].e_wd);
      chk($sformatf("row%0d.wix", i),   32'(wrob_ix_out),      32'(vec[i].e_wix));
      chk($sformatf("row%0d.cnt", i),   32'(count_out),        32'(vec[i].e_cnt));
      chk($sformatf("row%0d.rdy", i),   32'(alloc_ready_out),  32'(vec[i].e_rdy));
      chk($sformatf("row%0d.idx", i),   32'(alloc_idx_out),    32'(vec[i].e_idx));
      chk($sformatf("row%0d.flush", i), 32'(flush_out),        32'd0);
    end

    // ---- full buffer, refusal while committing, wrap of tail ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(5'(i + 1));
      tick();
    end
    chk("full.count", 32'(count_out), 32'd8);
    chk("full.ready", 32'(alloc_ready_out), 32'd0);
    chk("full.idx",   32'(alloc_idx_out), 32'd0);
    alloc(5'd20);
    tick();
    chk("full.9th_refused", 32'(count_out), 32'd8);
    cdb(3'd0, 32'hA0, 1'b0, 32'h0);
    tick();
    chk("full.cdb_count", 32'(count_out), 32'd8);
    cdb_valid_in = 0;
    tick();
    chk("full.commit_cv",  32'(commit_valid_out), 32'd1);
    chk("full.commit_wd",  wd_out, 32'hA0);
    chk("full.commit_cnt", 32'(count_out), 32'd7);
    chk("full.ready_back", 32'(alloc_ready_out), 32'd1);
    chk("full.idx_wrap",   32'(alloc_idx_out), 32'd0);
    tick();
    chk("full.regrant_cnt", 32'(count_out), 32'd8);
    chk("full.regrant_idx", 32'(alloc_idx_out), 32'd1);

    // ---- mispredict at head ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(5'(i + 1));
      tick();
    end
    idle();
    cdb(3'd0, 32'h40, 1'b1, 32'h100);
    tick();
    chk("mis.ready_blocked", 32'(alloc_ready_out), 32'd0);
    chk("mis.no_flush_yet",  32'(flush_out), 32'd0);
    alloc(5'd9);
    cdb(3'd2, 32'h77, 1'b0, 32'h0);
    tick();
    chk("mis.flush",  32'(flush_out), 32'd1);
    chk("mis.mask",   32'(flush_addrs_out), 32'h0E);
    chk("mis.pc",     redirect_pc_out, 32'h100);
    chk("mis.cv",     32'(commit_valid_out), 32'd1);
    chk("mis.wd",     wd_out, 32'h40);
    chk("mis.count",  32'(count_out), 32'd0);
    chk("mis.idx",    32'(alloc_idx_out), 32'd0);
    idle();
    tick();
    chk("mis.flush_pulse", 32'(flush_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      alloc(5'(i + 10));
      tick();
    end
    idle();
    cdb(3'd2, 32'h55, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    tick();
    chk("mis.no_commit_head_pending", 32'(commit_valid_out), 32'd0);
    chk("mis.count_after", 32'(count_out), 32'd3);

    // ---- reset mid-operation ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc(5'(i + 1));
      tick();
    end
    idle();
    cdb(3'd3, 32'h33, 1'b0, 32'h0);
    tick();
    cdb(3'd0, 32'h10, 1'b1, 32'h200);
    rst_in = 0;
    tick();
    chk("rst.count", 32'(count_out), 32'd0);
    chk("rst.cv",    32'(commit_valid_out), 32'd0);
    chk("rst.flush", 32'(flush_out), 32'd0);
    chk("rst.idx",   32'(alloc_idx_out), 32'd0);
    rst_in = 1;
    idle();
    tick();
    chk("rst.after_cv",    32'(commit_valid_out), 32'd0);
    chk("rst.after_flush", 32'(flush_out), 32'd0);

    // ---- randomized traffic against the queue model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int t;
      idle();
      if ($urandom_range(0, 299) == 0) rst_in = 0;
      else rst_in = 1;
      if ($urandom_range(0, 9) < 7) begin
        alloc_valid_in = 1;
        alloc_we_in    = 1'($urandom_range(0, 3) != 0);
        alloc_rd_in    = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 1) == 1) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          t = q[$urandom_range(0, q.size() - 1)].tag;
        else
          t = $urandom_range(0, SIZE - 1);
        if (!tag_done(t)) begin
          cdb_valid_in      = 1;
          cdb_idx_in        = 3'(t);
          cdb_data_in       = $urandom;
          cdb_mispredict_in = 1'($urandom_range(0, 15) == 0);
          cdb_target_in     = $urandom;
        end
      end
      tick();
    end
    rst_in = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
